// File: rtl/axil_adder_master_if.sv
// AXI4-Lite bus bundle between the adder master and the memory-mapped adder slave.
interface axil_adder_master_if #(
    parameter int ADDR_W = 32
);
    logic [ADDR_W-1:0] awaddr;
    logic [2:0]        awprot;
    logic              awvalid;
    logic              awready;
    logic [31:0]       wdata;
    logic [3:0]        wstrb;
    logic              wvalid;
    logic              wready;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;
    logic [ADDR_W-1:0] araddr;
    logic [2:0]        arprot;
    logic              arvalid;
    logic              arready;
    logic [31:0]       rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rready;

    modport master (
        output awaddr, awprot, awvalid, input awready,
        output wdata, wstrb, wvalid, input wready,
        input bresp, bvalid, output bready,
        output araddr, arprot, arvalid, input arready,
        input rdata, rresp, rvalid, output rready
    );

    modport slave (
        input awaddr, awprot, awvalid, output awready,
        input wdata, wstrb, wvalid, output wready,
        output bresp, bvalid, input bready,
        input araddr, arprot, arvalid, output arready,
        output rdata, rresp, rvalid, input rready
    );
endinterface

// File: rtl/axil_adder_master.sv
// AXI4-Lite master driving the adder slave: writes A (0x00) and B (0x04),
// reads the result register (0x48), and returns the sum with an error flag.
module axil_adder_master #(
    parameter int              ADDR_W      = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter bit              DOUBLE_READ = 1'b1,
    parameter int              TIMEOUT     = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [31:0] cmd_a,
    input  logic [31:0] cmd_b,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [31:0] res_data,
    output logic        res_err,
    output logic        busy,
    axil_adder_master_if.master m_axil
);

    typedef enum logic [2:0] {
        IDLE, WA, WA_B, WB, WB_B, RD, RD_R, DONE
    } state_t;

    localparam logic [ADDR_W-1:0] ADDR_A   = BASE_ADDR + ADDR_W'(32'h00);
    localparam logic [ADDR_W-1:0] ADDR_B   = BASE_ADDR + ADDR_W'(32'h04);
    localparam logic [ADDR_W-1:0] ADDR_RES = BASE_ADDR + ADDR_W'(32'h48);
    localparam int                TW       = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TW-1:0]     TMO_LAST = TW'(TIMEOUT - 1);

    state_t            state_q, state_d;
    logic [31:0]       b_q, b_d;
    logic [ADDR_W-1:0] awaddr_q, awaddr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [ADDR_W-1:0] araddr_q, araddr_d;
    logic              awvalid_q, awvalid_d;
    logic              wvalid_q, wvalid_d;
    logic              bready_q, bready_d;
    logic              arvalid_q, arvalid_d;
    logic              rready_q, rready_d;
    logic              rd_cnt_q, rd_cnt_d;
    logic              err_q, err_d;
    logic              res_valid_q, res_valid_d;
    logic [31:0]       res_data_q, res_data_d;
    logic [TW-1:0]     tmo_q, tmo_d;
    logic              tmo_hit;

    // The waited-on handshake has used up its budget when the counter sits on its last value.
    assign tmo_hit = (TIMEOUT != 0) && (tmo_q == TMO_LAST);

    // Next-state and next-output logic; every AXI output is registered so no ready reaches a valid combinationally.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
        state_d     = state_q;
        b_d         = b_q;
        awaddr_d    = awaddr_q;
        wdata_d     = wdata_q;
        araddr_d    = araddr_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        bready_d    = bready_q;
        arvalid_d   = arvalid_q;
        rready_d    = rready_q;
        rd_cnt_d    = rd_cnt_q;
        err_d       = err_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;

        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    b_d       = cmd_b;
                    wdata_d   = cmd_a;
                    awaddr_d  = ADDR_A;
                    awvalid_d = 1'b1;
                    wvalid_d  = 1'b1;
                    err_d     = 1'b0;
                    rd_cnt_d  = 1'b0;
                    state_d   = WA;
                end
            end
            WA, WB: begin
                if (awvalid_q && m_axil.awready) awvalid_d = 1'b0;
                if (wvalid_q && m_axil.wready)   wvalid_d  = 1'b0;
                if (!awvalid_d && !wvalid_d) begin
                    bready_d = 1'b1;
                    state_d  = (state_q == WA) ? WA_B : WB_B;
                end
            end
            WA_B, WB_B: begin
                if (m_axil.bvalid) begin
                    bready_d = 1'b0;
                    err_d    = err_q | (m_axil.bresp != 2'b00);
                    if (state_q == WA_B) begin
                        awaddr_d  = ADDR_B;
                        wdata_d   = b_q;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = WB;
                    end else begin
                        araddr_d  = ADDR_RES;
                        arvalid_d = 1'b1;
                        state_d   = RD;
                    end
                end
            end
            RD: begin
                if (m_axil.arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = RD_R;
                end
            end
            RD_R: begin
                if (m_axil.rvalid) begin
                    rready_d = 1'b0;
                    err_d    = err_q | (m_axil.rresp != 2'b00);
                    // The slave refreshes its result on read, so the first beat is stale.
                    if (DOUBLE_READ && !rd_cnt_q) begin
                        rd_cnt_d  = 1'b1;
                        arvalid_d = 1'b1;
                        state_d   = RD;
                    end else begin
                        res_valid_d = 1'b1;
                        res_data_d  = err_d ? 32'h0 : m_axil.rdata;
                        state_d     = DONE;
                    end
                end
            end
            DONE: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
        endcase

        // A stuck handshake abandons the transaction and reports it as an error.
        if (state_d == state_q && state_q != IDLE && state_q != DONE && tmo_hit) begin
            awvalid_d   = 1'b0;
            wvalid_d    = 1'b0;
            bready_d    = 1'b0;
            arvalid_d   = 1'b0;
            rready_d    = 1'b0;
            err_d       = 1'b1;
            res_valid_d = 1'b1;
            res_data_d  = 32'h0;
            state_d     = DONE;
        end

        if (state_d != state_q || state_q == IDLE || state_q == DONE) tmo_d = '0;
        else                                                         tmo_d = tmo_q + 1'b1;
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments here so every flop samples the pre-edge values, never a neighbour's new one.
        if (!rst_n) begin
            state_q     <= IDLE;
            b_q         <= '0;
            awaddr_q    <= '0;
            wdata_q     <= '0;
            araddr_q    <= '0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            rd_cnt_q    <= 1'b0;
            err_q       <= 1'b0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            tmo_q       <= '0;
        end else begin
            state_q     <= state_d;
            b_q         <= b_d;
            awaddr_q    <= awaddr_d;
            wdata_q     <= wdata_d;
            araddr_q    <= araddr_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            bready_q    <= bready_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            rd_cnt_q    <= rd_cnt_d;
            err_q       <= err_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            tmo_q       <= tmo_d;
        end
    end

    assign cmd_ready      = (state_q == IDLE);
    assign busy           = (state_q != IDLE);
    assign res_valid      = res_valid_q;
    assign res_data       = res_data_q;
    assign res_err        = err_q;

    assign m_axil.awaddr  = awaddr_q;
    assign m_axil.awprot  = 3'b000;
    assign m_axil.awvalid = awvalid_q;
    assign m_axil.wdata   = wdata_q;
    assign m_axil.wstrb   = 4'hF;
    assign m_axil.wvalid  = wvalid_q;
    assign m_axil.bready  = bready_q;
    assign m_axil.araddr  = araddr_q;
    assign m_axil.arprot  = 3'b000;
    assign m_axil.arvalid = arvalid_q;
    assign m_axil.rready  = rready_q;

endmodule

// File: tb/tb_axil_adder_master.sv
// Self-checking bench for axil_adder_master with a behavioural adder slave
// whose result register refreshes on every read.
module tb_axil_adder_master;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [31:0] cmd_a = '0;
    logic [31:0] cmd_b = '0;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [31:0] res_data;
    logic        res_err;
    logic        busy;

    int n_checks = 0;
    int n_err    = 0;

    // Slave behaviour knobs, changed only while the master is idle.
    int   w_delay    = 0;
    logic b_err      = 1'b0;
    logic ar_ok      = 1'b1;
    logic allow_drop = 1'b0;

    axil_adder_master_if #(.ADDR_W(32)) axil ();

    axil_adder_master #(
        .ADDR_W     (32),
        .BASE_ADDR  (32'h0),
        .DOUBLE_READ(1'b1),
        .TIMEOUT    (16)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_a    (cmd_a),
        .cmd_b    (cmd_b),
        .res_valid(res_valid),
        .res_ready(res_ready),
        .res_data (res_data),
        .res_err  (res_err),
        .busy     (busy),
        .m_axil   (axil)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    // ---------------- slave model ----------------
    logic        aw_have = 1'b0, w_have = 1'b0;
    logic [31:0] aw_lat = '0, w_lat = '0;
    int          w_cnt = 0;
    logic        s_bvalid = 1'b0;
    logic [1:0]  s_bresp = 2'b00;
    logic        s_rvalid = 1'b0;
    logic [31:0] s_rdata = '0;
    logic [31:0] reg_a = '0, reg_b = '0, reg_sum = '0;
    logic [31:0] aw_log [64];
    logic [31:0] w_log [64];
    int          aw_n = 0;
    int          ar_n = 0;
    logic [31:0] ar_last = '0;

    assign axil.awready = 1'b1;
    assign axil.wready  = (w_delay == 0) ? 1'b1 : (aw_have && !w_have && (w_cnt >= w_delay - 1));
    assign axil.bvalid  = s_bvalid;
    assign axil.bresp   = s_bresp;
    assign axil.arready = ar_ok;
    assign axil.rvalid  = s_rvalid;
    assign axil.rdata   = s_rdata;
    assign axil.rresp   = 2'b00;

    always @(posedge clk) begin
        if (!rst_n) begin
            aw_have  <= 1'b0;
            w_have   <= 1'b0;
            w_cnt    <= 0;
            s_bvalid <= 1'b0;
            s_bresp  <= 2'b00;
            s_rvalid <= 1'b0;
            s_rdata  <= '0;
            reg_a    <= '0;
            reg_b    <= '0;
            reg_sum  <= '0;
        end else begin
            if (axil.awvalid && axil.awready) begin
                aw_have <= 1'b1;
                aw_lat  <= axil.awaddr;
                w_cnt   <= 0;
            end else if (aw_have) begin
                w_cnt <= w_cnt + 1;
            end
            if (axil.wvalid && axil.wready) begin
                w_have <= 1'b1;
                w_lat  <= axil.wdata;
            end
            if (aw_have && w_have && !s_bvalid) begin
                aw_have <= 1'b0;
                w_have  <= 1'b0;
                if (aw_lat == 32'h0) reg_a <= w_lat;
                if (aw_lat == 32'h4) reg_b <= w_lat;
                aw_log[aw_n % 64] <= aw_lat;
                w_log[aw_n % 64]  <= w_lat;
                aw_n     <= aw_n + 1;
                s_bvalid <= 1'b1;
                s_bresp  <= (b_err && aw_lat == 32'h4) ? 2'b10 : 2'b00;
            end else if (s_bvalid && axil.bready) begin
                s_bvalid <= 1'b0;
            end
            if (axil.arvalid && axil.arready) begin
                s_rvalid <= 1'b1;
                s_rdata  <= reg_sum;
                reg_sum  <= reg_a + reg_b;
                ar_n     <= ar_n + 1;
                ar_last  <= axil.araddr;
            end else if (s_rvalid && axil.rready) begin
                s_rvalid <= 1'b0;
            end
        end
    end

    // ---------------- monitors ----------------
    int   split_n = 0, ar_hi_n = 0, viol_n = 0, cmd_hs = 0;
    logic p_aw = 1'b0, p_w = 1'b0, p_ar = 1'b0;

    always @(posedge clk) begin
        if (rst_n && cmd_valid && cmd_ready) cmd_hs <= cmd_hs + 1;
    end

    always @(negedge clk) begin
        if (rst_n) begin
            split_n <= split_n + int'(!axil.awvalid && axil.wvalid);
            ar_hi_n <= ar_hi_n + int'(axil.arvalid);
            if (!allow_drop && ((p_aw && !axil.awvalid) || (p_w && !axil.wvalid) || (p_ar && !axil.arvalid)))
                viol_n <= viol_n + 1;
        end
        p_aw <= rst_n && axil.awvalid && !axil.awready;
        p_w  <= rst_n && axil.wvalid && !axil.wready;
        p_ar <= rst_n && axil.arvalid && !axil.arready;
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_reset_state(input string tag);
        check($sformatf("%s_cmd_ready", tag), 32'(cmd_ready), 32'd1);
        check($sformatf("%s_busy", tag), 32'(busy), 32'd0);
        check($sformatf("%s_res", tag), {29'b0, res_valid, res_err, |res_data}, 32'd0);
        check($sformatf("%s_valids", tag),
              32'({axil.awvalid, axil.wvalid, axil.bready, axil.arvalid, axil.rready}), 32'd0);
        check($sformatf("%s_addr_data", tag), axil.awaddr | axil.wdata | axil.araddr, 32'd0);
    endtask

    // Called at a negedge; returns at the negedge after the command handshake.
    task automatic send_cmd(input logic [31:0] a, input logic [31:0] b);
        int n = 0;
        cmd_a = a;
        cmd_b = b;
        cmd_valid = 1'b1;
        while (!cmd_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("cmd_accepted", 32'(cmd_ready), 32'd1);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_res(output logic [31:0] d, output logic e);
        int n = 0;
        while (!res_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("res_valid_seen", 32'(res_valid), 32'd1);
        d = res_data;
        e = res_err;
    endtask

    task automatic accept_res();
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
    endtask

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        int          w_delay;
        logic        b_err;
        logic [31:0] exp_data;
        logic        exp_err;
    } vec_t;

    task automatic run_vec(input int i, input vec_t v);
        int          aw0, ar0, sp0;
        logic [31:0] d;
        logic        e;
        w_delay = v.w_delay;
        b_err   = v.b_err;
        aw0 = aw_n;
        ar0 = ar_n;
        sp0 = split_n;
        send_cmd(v.a, v.b);
        wait_res(d, e);
        check($sformatf("v%0d_res_data", i), d, v.exp_data);
        check($sformatf("v%0d_res_err", i), 32'(e), 32'(v.exp_err));
        check($sformatf("v%0d_cmd_ready_done", i), 32'(cmd_ready), 32'd0);
        accept_res();
        check($sformatf("v%0d_aw_count", i), 32'(aw_n - aw0), 32'd2);
        check($sformatf("v%0d_aw_addr_a", i), aw_log[aw0 % 64], 32'h0);
        check($sformatf("v%0d_aw_addr_b", i), aw_log[(aw0 + 1) % 64], 32'h4);
        check($sformatf("v%0d_wdata_a", i), w_log[aw0 % 64], v.a);
        check($sformatf("v%0d_wdata_b", i), w_log[(aw0 + 1) % 64], v.b);
        check($sformatf("v%0d_ar_count", i), 32'(ar_n - ar0), 32'd2);
        check($sformatf("v%0d_ar_addr", i), ar_last, 32'h48);
        check($sformatf("v%0d_split_cycles", i), 32'(split_n - sp0), 32'(2 * v.w_delay));
        w_delay = 0;
        b_err   = 1'b0;
    endtask

    // ---------------- test sequence ----------------
    initial begin
        vec_t        vecs [6];
        logic [31:0] d;
        logic        e;
        int          base, snap, n, bad;

        vecs[0] = '{32'd5,         32'd7,         0, 1'b0, 32'd12,        1'b0};
        vecs[1] = '{32'd100,       32'd200,       3, 1'b0, 32'd300,       1'b0};
        vecs[2] = '{32'd9,         32'd10,        0, 1'b1, 32'd0,         1'b1};
        vecs[3] = '{32'd1234,      32'd1,         0, 1'b0, 32'd1235,      1'b0};
        vecs[4] = '{32'h80000000,  32'h80000000,  0, 1'b0, 32'd0,         1'b0};
        vecs[5] = '{32'd0,         32'hFFFFFFFF,  1, 1'b0, 32'hFFFFFFFF,  1'b0};

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_state("reset");
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);

        // Back-to-back: the second command is held valid while the first is in flight.
        base = cmd_hs;
        send_cmd(32'hFFFFFFFF, 32'd2);
        cmd_a = 32'd3;
        cmd_b = 32'd4;
        cmd_valid = 1'b1;
        wait_res(d, e);
        check("b2b_first_sum", d, 32'd1);
        check("b2b_no_accept_while_busy", 32'(cmd_hs - base), 32'd1);
        accept_res();
        check("b2b_bubble_cmd_ready", 32'(cmd_ready), 32'd1);
        snap = aw_n;
        @(negedge clk);
        cmd_valid = 1'b0;
        check("b2b_second_accept", 32'(cmd_hs - base), 32'd2);
        wait_res(d, e);
        check("b2b_second_sum", d, 32'd7);
        check("b2b_second_wdata_a", w_log[snap % 64], 32'd3);
        accept_res();

        // Timeout: arready never rises, so arvalid is withdrawn after 16 cycles.
        ar_ok = 1'b0;
        allow_drop = 1'b1;
        snap = ar_hi_n;
        base = ar_n;
        send_cmd(32'd1, 32'd1);
        wait_res(d, e);
        check("tmo_res_err", 32'(e), 32'd1);
        check("tmo_res_data", d, 32'd0);
        check("tmo_arvalid_low", 32'(axil.arvalid), 32'd0);
        check("tmo_arvalid_cycles", 32'(ar_hi_n - snap), 32'd16);
        check("tmo_no_ar_handshake", 32'(ar_n - base), 32'd0);
        accept_res();
        ar_ok = 1'b1;
        @(negedge clk);
        allow_drop = 1'b0;

        // Reset while waiting for read data.
        send_cmd(32'd20, 32'd22);
        n = 0;
        while (!axil.rready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("mid_reached_rd_r", 32'(axil.rready), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_state("mid_reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Result held for 10 cycles with res_ready low.
        send_cmd(32'd6, 32'd6);
        wait_res(d, e);
        check("hold_sum", d, 32'd12);
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (res_valid !== 1'b1 || res_data !== 32'd12 || res_err !== 1'b0 || cmd_ready !== 1'b0)
                bad++;
        end
        check("hold_stable_cycles_bad", 32'(bad), 32'd0);
        accept_res();
        check("hold_released_res_valid", 32'(res_valid), 32'd0);
        check("hold_released_cmd_ready", 32'(cmd_ready), 32'd1);

        repeat (2) @(negedge clk);
        check("valid_drop_violations", 32'(viol_n), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
